ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch front end: the consumer side of the program counter. It owns the PC register and drives a request/acknowledge read interface to instruction memory.
- It fills the IF/ID pipeline register, honours hazard stalls from the hazard unit, and applies branch/jump redirects with flush.
- Sits between the jump/branch mux, instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h00003000, PC value after reset (text-segment base).
- NOP_INSTR, 32'h00000000, instruction word presented on if_instr when slot is invalid.
- WAIT_LIMIT, 16, max cycles a request may wait for imem_ack before fetch_err sets.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- hazard  in  1  stall: IF/ID register and PC must hold.
- redirect  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC for redirect.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of request; stable while imem_req high.
- imem_ack  in  1  read data valid this cycle; completes the request.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- if_valid  out  1  IF/ID slot holds a real instruction.
- if_instr  out  32  IF/ID instruction (NOP_INSTR when invalid).
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4 (wraps modulo 2^32).
- fetch_err  out  1  sticky: misaligned redirect or ack timeout.

Behaviour:
- Reset (sync, high) values:
  - pc=RESET_PC; state=ISSUE; imem_req=0; imem_addr=RESET_PC.
  - if_valid=0; if_instr=NOP_INSTR; if_pc=0; if_pc_plus4=0.
  - fetch_err=0; wait counter=0; hold buffer empty.
- Reset mid-request abandons the request; memory must tolerate req dropping on reset.
- Request protocol:
  - imem_req is registered; first request asserts the cycle after reset deasserts.
  - imem_addr stays constant from req rise until the cycle ack=1.
  - Request completes on the cycle imem_ack=1; req may deassert or re-issue next cycle.
  - imem_ack with imem_req=0 is ignored.
- States:
  - ISSUE: req=1, addr=pc.
    - On ack, hazard=0, redirect=0: IF/ID <= {1, rdata, pc, pc+4}; pc <= pc+4; stay ISSUE (one instruction per cycle with zero-wait memory).
    - On ack with hazard=1: capture rdata/pc into hold buffer; pc <= pc+4; go HOLD; req=0.
  - HOLD: req=0.
    - When hazard=0: IF/ID <= buffer; go ISSUE.
  - DRAIN: req=1, addr=stale address. Wait for ack, discard data; then ISSUE at pc.
- Hazard with no ack pending: IF/ID and pc hold; request stays outstanding.
- Redirect (highest priority, beats hazard and ack):
  - pc <= {redirect_pc[31:2], 2'b00}; IF/ID <= {0, NOP_INSTR, 0, 0}; hold buffer cleared.
  - If a request is outstanding and ack=0 this cycle: go DRAIN.
  - Else (ack=1 or state HOLD): go ISSUE; any data from this ack is discarded.
  - redirect_pc[1:0] != 0 sets fetch_err.
- Timeout: wait counter counts cycles with req=1 and ack=0.
  - Reaching WAIT_LIMIT sets fetch_err; the fetch keeps waiting.
  - Counter clears on ack.
- fetch_err is cleared only by reset.
- pc+4 wraps 32'hFFFFFFFC -> 32'h00000000 silently.

Decomposition:
- Shared package: state encoding (ISSUE, HOLD, DRAIN), RESET_PC and NOP_INSTR constants, instruction width.
- One natural sub-module: ifid_reg (IF/ID register with load, hold and flush controls), reused by later stage registers.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req): imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_pc follows one cycle later; if_pc_plus4 = 0x3004 for if_pc 0x3000.
- Hazard held 3 cycles while ack arrives: IF/ID frozen; imem_req=0 in HOLD; when hazard drops, if_instr = captured word, if_pc=0x3004; next addr 0x3008.
- Redirect to 0x3100 while request at 0x3008 waits (ack delayed 2 cycles): if_valid=0 next cycle; imem_addr stays 0x3008 until ack; data discarded; next request at 0x3100.
- Redirect and hazard asserted in the same cycle as ack: redirect wins; if_valid=0; next fetch at target.
- Redirect to 0x3102: fetch_err=1; next fetch address 0x3100; fetch_err stays 1 until reset.
- Ack withheld 16 cycles: fetch_err rises after the WAIT_LIMIT cycle; a later ack still loads IF/ID; reset asserted mid-wait returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end and its
// pipeline-register building blocks.
package ifetch_unit_pkg;
    localparam int          INSTR_W       = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic [31:0]        pc_plus4;
    } ifid_t;
endpackage

// File: rtl/ifetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush empties the slot, load captures d,
// otherwise the contents hold.
module ifid_reg
    import ifetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);
    localparam ifid_t EMPTY = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

    always_ff @(posedge clk) begin
        if (reset || flush) q <= EMPTY;
        else if (load)      q <= d;
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack read to
// instruction memory and fills the IF/ID register under stall and redirect.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0]        RESET_PC   = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_DEF,
    parameter int                 WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hazard,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               fetch_err
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    fetch_state_t       state, state_n;
    logic [31:0]        pc, pc_n, pc_plus4;
    logic [INSTR_W-1:0] hold_instr, hold_instr_n;
    logic [31:0]        hold_pc, hold_pc_n;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
    logic               err_n, req_n, ack_ok;
    logic [31:0]        addr_n;
    logic               ifid_load, ifid_flush;
    ifid_t              ifid_d, ifid_q;

    always_comb begin
        ack_ok       = imem_req & imem_ack;
        pc_plus4     = pc + 32'd4;
        state_n      = state;
        pc_n         = pc;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        err_n        = fetch_err;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_d       = '{valid: 1'b1, instr: imem_rdata, pc: pc, pc_plus4: pc_plus4};

        if (redirect) begin
            pc_n         = {redirect_pc[31:2], 2'b00};
            ifid_flush   = 1'b1;
            hold_instr_n = NOP_INSTR;
            hold_pc_n    = 32'h0;
            // An unanswered request must still be drained before refetching.
            state_n      = (imem_req && !imem_ack) ? DRAIN : ISSUE;
            if (redirect_pc[1:0] != 2'b00) err_n = 1'b1;
        end else begin
            case (state)
                ISSUE: begin
                    if (ack_ok) begin
                        pc_n = pc_plus4;
                        if (hazard) begin
                            hold_instr_n = imem_rdata;
                            hold_pc_n    = pc;
                            state_n      = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!hazard) begin
                        // Decode consumed the slot and nothing arrived: bubble.
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!hazard) begin
                        ifid_load = 1'b1;
                        ifid_d    = '{valid: 1'b1, instr: hold_instr, pc: hold_pc,
                                      pc_plus4: hold_pc + 32'd4};
                        state_n   = ISSUE;
                    end
                end
                DRAIN: begin
                    if (ack_ok)  state_n    = ISSUE;
                    if (!hazard) ifid_flush = 1'b1;
                end
                default: state_n = ISSUE;
            endcase
        end

        wait_cnt_n = wait_cnt;
        if (ack_ok) begin
            wait_cnt_n = '0;
        end else if (imem_req && wait_cnt != CNT_W'(WAIT_LIMIT)) begin
            wait_cnt_n = wait_cnt + 1'b1;
        end
        if (wait_cnt_n == CNT_W'(WAIT_LIMIT)) err_n = 1'b1;

        // DRAIN keeps presenting the abandoned address until its ack.
        req_n  = (state_n != HOLD);
        addr_n = (state_n == ISSUE) ? pc_n : imem_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'h0;
            wait_cnt   <= '0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_req   <= req_n;
            imem_addr  <= addr_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
            wait_cnt   <= wait_cnt_n;
            fetch_err  <= err_n;
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign if_valid    = ifid_q.valid;
    assign if_instr    = ifid_q.instr;
    assign if_pc       = ifid_q.pc;
    assign if_pc_plus4 = ifid_q.pc_plus4;
endmodule
